// File: rtl/demux4_fifo.sv
// demux4_fifo: one-to-four result distributor with per-destination buffering.
//   A single producer stream tagged with a 2-bit destination is steered into
//   one of four independent FIFOs, and each FIFO drains on its own
//   valid/ready handshake. This keeps a stall on one consumer from holding
//   up the producer when the entry is meant for another consumer.
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   flush           synchronous clear of all four FIFOs
//   in_valid/ready  producer handshake; in_sel picks the FIFO, in_data is the payload
//   out_valid[i]    FIFO i is non-empty
//   out_ready[i]    consumer i takes the head entry this cycle
//   out_data        slice [i*WIDTH +: WIDTH] = head entry of FIFO i
//   out_count       slice i = occupancy of FIFO i, 0..DEPTH

// One destination FIFO: circular buffer with wrapping pointers and an
// explicit occupancy count, so full and empty are easy to tell apart.
module demux4_fifo_lane #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_ready,
  output logic                     valid,
  output logic                     full,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]              wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic                       rd;

  assign valid   = (cnt_q != '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign rd_data = mem_q[rp_q];
  assign count   = cnt_q;

  // Reading an empty FIFO is a no-op.
  assign rd = rd_ready & valid;

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    mem_d = mem_q;
    if (clr) begin
      // Flush drops buffered entries and ignores any output handshake.
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (wr_en) begin
        mem_d[wp_q] = wr_data;
        wp_d        = wp_q + AW'(1);
      end
      if (rd) rp_d = rp_q + AW'(1);
      case ({wr_en, rd})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage is deliberately left out of reset; only the pointers matter.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

module demux4_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [1:0]                     in_sel,
  input  logic [WIDTH-1:0]               in_data,
  output logic [3:0]                     out_valid,
  input  logic [3:0]                     out_ready,
  output logic [4*WIDTH-1:0]             out_data,
  output logic [4*($clog2(DEPTH)+1)-1:0] out_count
);
  localparam int NUM_LANES = 4;
  localparam int CW        = $clog2(DEPTH) + 1;

  logic [NUM_LANES-1:0]            lane_full;
  logic [NUM_LANES-1:0]            lane_wr;
  logic [NUM_LANES-1:0][WIDTH-1:0] lane_data;
  logic [NUM_LANES-1:0][CW-1:0]    lane_cnt;

  // A full FIFO refuses input even when it is being read this cycle; this
  // keeps in_ready off the out_ready path.
  assign in_ready  = ~rst & ~flush & ~lane_full[in_sel];
  assign out_data  = lane_data;
  assign out_count = lane_cnt;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lane_wr[i] = in_valid & in_ready & (in_sel == 2'(i));

    demux4_fifo_lane #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .clr      (flush),
      .wr_en    (lane_wr[i]),
      .wr_data  (in_data),
      .rd_ready (out_ready[i]),
      .valid    (out_valid[i]),
      .full     (lane_full[i]),
      .rd_data  (lane_data[i]),
      .count    (lane_cnt[i])
    );
  end
endmodule
